tile_raster_engine: RTL

TILE_RASTER_ENGINE -- requirements
Module: tile_raster_engine

---
 rtl/tile_raster_engine_if.sv | 69 ++++++
 rtl/tile_raster_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_raster_engine_if.sv
// Bus bundle for tile_raster_engine: command/status, triangle BRAM read port,
// tile BRAM read/write ports and the external pixel-calculator channel.
// master = engine side, slave = environment (memories, calculator, host).
interface tile_raster_engine_if #(
  parameter int MAX_TRIANGLES = 256,
  parameter int TILE_W        = 20,
  parameter int TILE_H        = 45,
  parameter int X_W           = 9,
  parameter int Y_W           = 8,
  parameter int PIX_W         = 32,
  parameter int TRI_W         = 128
);
  localparam int NUM_W   = $clog2(MAX_TRIANGLES) + 1;
  localparam int TRI_AW  = $clog2(MAX_TRIANGLES);
  localparam int TILE_AW = $clog2(TILE_W * TILE_H);

  // command / status
  logic               start;
  logic               do_wipe;
  logic               do_paint;
  logic [PIX_W-1:0]   wipe_value;
  logic [NUM_W-1:0]   num_triangles;
  logic [X_W-1:0]     x_offset;
  logic [Y_W-1:0]     y_offset;
  logic               busy;
  logic               done;

  // triangle BRAM
  logic [TRI_AW-1:0]  tri_rd_addr;
  logic [TRI_W-1:0]   tri_rd_data;

  // tile BRAM
  logic [TILE_AW-1:0] tile_rd_addr;
  logic [PIX_W-1:0]   tile_rd_data;
  logic [TILE_AW-1:0] tile_wr_addr;
  logic               tile_wr_en;
  logic [PIX_W-1:0]   tile_wr_data;

  // pixel calculator
  logic               calc_in_valid;
  logic [X_W-1:0]     calc_x;
  logic [Y_W-1:0]     calc_y;
  logic [PIX_W-1:0]   calc_pixel;
  logic [TRI_W-1:0]   calc_tri;
  logic               calc_out_valid;
  logic [PIX_W-1:0]   calc_pixel_out;

  modport master (
    input  start, do_wipe, do_paint, wipe_value, num_triangles, x_offset, y_offset,
    output busy, done,
    output tri_rd_addr,
    input  tri_rd_data,
    output tile_rd_addr, tile_wr_addr, tile_wr_en, tile_wr_data,
    input  tile_rd_data,
    output calc_in_valid, calc_x, calc_y, calc_pixel, calc_tri,
    input  calc_out_valid, calc_pixel_out
  );

  modport slave (
    output start, do_wipe, do_paint, wipe_value, num_triangles, x_offset, y_offset,
    input  busy, done,
    input  tri_rd_addr,
    output tri_rd_data,
    input  tile_rd_addr, tile_wr_addr, tile_wr_en, tile_wr_data,
    output tile_rd_data,
    input  calc_in_valid, calc_x, calc_y, calc_pixel, calc_tri,
    output calc_out_valid, calc_pixel_out
  );
endinterface

// File: rtl/tile_raster_engine.sv
// tile_raster_engine: wipes a TILE_W x TILE_H tile buffer and/or paints it by
// streaming every pixel of the tile through an external pixel calculator once
// per triangle. Tile reads and calculator results are tracked by a valid/address
// pipeline so writes land on the pixel that was read TILE_RD_LAT+CALC_LAT earlier.
// Optional feature: define TILE_RASTER_PERF_EN to add perf_cycles / perf_tris.
module tile_raster_engine #(
  parameter int MAX_TRIANGLES = 256,
  parameter int TILE_W        = 20,
  parameter int TILE_H        = 45,
  parameter int X_W           = 9,
  parameter int Y_W           = 8,
  parameter int PIX_W         = 32,
  parameter int TRI_W         = 128,
  parameter int TRI_RD_LAT    = 2,
  parameter int TILE_RD_LAT   = 2,
  parameter int CALC_LAT      = 2
) (
  input  logic clk,
  input  logic rst_n,
  tile_raster_engine_if.master bus
`ifdef TILE_RASTER_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [15:0] perf_tris
`endif
);

  localparam int NUM_W   = $clog2(MAX_TRIANGLES) + 1;
  localparam int TRI_AW  = $clog2(MAX_TRIANGLES);
  localparam int PIX_N   = TILE_W * TILE_H;
  localparam int TILE_AW = $clog2(PIX_N);
  localparam int OX_W    = $clog2(TILE_W + 1);
  localparam int OY_W    = $clog2(TILE_H + 1);
  localparam int WR_LAT  = TILE_RD_LAT + CALC_LAT;
  localparam int FC_W    = $clog2(TRI_RD_LAT + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WIPE, S_FETCH, S_ITER, S_DRAIN, S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic               accept;

  // command captured at accept
  logic               paint_reg;
  logic [NUM_W-1:0]   num_reg;
  logic [X_W-1:0]     x_off_reg;
  logic [Y_W-1:0]     y_off_reg;
  logic [PIX_W-1:0]   wipe_val_reg;

  // sequencing
  logic [NUM_W-1:0]   idx_reg;
  logic [TILE_AW-1:0] wipe_addr_reg;
  logic [FC_W-1:0]    fetch_cnt_reg;
  logic [TRI_W-1:0]   tri_reg;

  // tile scan
  logic [OX_W-1:0]    ox_reg;
  logic [OY_W-1:0]    oy_reg;
  logic [X_W-1:0]     cx_reg;
  logic [Y_W-1:0]     cy_reg;
  logic [TILE_AW-1:0] rd_addr_reg;

  // read -> calc -> write tracking pipeline
  logic [WR_LAT-1:0]  vld_pipe;
  logic [TILE_AW-1:0] addr_pipe [WR_LAT];
  logic [X_W-1:0]     x_pipe [TILE_RD_LAT];
  logic [Y_W-1:0]     y_pipe [TILE_RD_LAT];

  logic [NUM_W-1:0]   num_clamped;
  logic               last_pix;
  logic               more_tris;
  logic               inflight;
  logic               fetch_ready;
  logic               wipe_last;

  assign num_clamped = (bus.num_triangles > NUM_W'(MAX_TRIANGLES)) ?
                       NUM_W'(MAX_TRIANGLES) : bus.num_triangles;
  assign last_pix    = (ox_reg == OX_W'(TILE_W - 1)) && (oy_reg == OY_W'(TILE_H - 1));
  assign more_tris   = (idx_reg + NUM_W'(1)) < num_reg;
  // any tracked pixel still between its read and its write slot
  assign inflight    = |vld_pipe;
  // triangle word has arrived and the previous triangle's writes have all landed
  assign fetch_ready = (fetch_cnt_reg == FC_W'(TRI_RD_LAT)) && !inflight;
  assign wipe_last   = (wipe_addr_reg == TILE_AW'(PIX_N - 1));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // next-state logic and command acceptance
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (bus.do_wipe)       state_next = S_WIPE;
          else if (bus.do_paint) state_next = (num_clamped == '0) ? S_DRAIN : S_FETCH;
          else                   state_next = S_DONE;
        end
      end
      S_WIPE: begin
        if (wipe_last) begin
          if (!paint_reg)          state_next = S_DONE;
          else if (num_reg == '0)  state_next = S_DRAIN;
          else                     state_next = S_FETCH;
        end
      end
      S_FETCH: if (fetch_ready) state_next = S_ITER;
      S_ITER:  if (last_pix)    state_next = more_tris ? S_FETCH : S_DRAIN;
      S_DRAIN: if (!inflight)   state_next = S_DONE;
      S_DONE:                   state_next = S_IDLE;
      default:                  state_next = S_IDLE;
    endcase
  end

  // command capture, triangle index, wipe address and triangle fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paint_reg     <= 1'b0;
      num_reg       <= '0;
      x_off_reg     <= '0;
      y_off_reg     <= '0;
      wipe_val_reg  <= '0;
      idx_reg       <= '0;
      wipe_addr_reg <= '0;
      fetch_cnt_reg <= '0;
      tri_reg       <= '0;
    end else begin
      if (accept) begin
        paint_reg     <= bus.do_paint;
        num_reg       <= num_clamped;
        x_off_reg     <= bus.x_offset;
        y_off_reg     <= bus.y_offset;
        wipe_val_reg  <= bus.wipe_value;
        idx_reg       <= '0;
        wipe_addr_reg <= '0;
      end else begin
        if (state_reg == S_WIPE) wipe_addr_reg <= wipe_addr_reg + TILE_AW'(1);
        if (state_reg == S_ITER && last_pix && more_tris) idx_reg <= idx_reg + NUM_W'(1);
      end
      // latency counter restarts on every FETCH entry and saturates
      if (state_reg != S_FETCH)
        fetch_cnt_reg <= '0;
      else if (fetch_cnt_reg != FC_W'(TRI_RD_LAT))
        fetch_cnt_reg <= fetch_cnt_reg + FC_W'(1);
      if (state_reg == S_FETCH && fetch_ready) tri_reg <= bus.tri_rd_data;
    end
  end

  // raster scan of the tile: ox inner, oy outer, screen coords tracked alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox_reg      <= '0;
      oy_reg      <= '0;
      cx_reg      <= '0;
      cy_reg      <= '0;
      rd_addr_reg <= '0;
    end else if (state_reg != S_ITER) begin
      ox_reg      <= '0;
      oy_reg      <= '0;
      cx_reg      <= x_off_reg;
      cy_reg      <= y_off_reg;
      rd_addr_reg <= '0;
    end else begin
      rd_addr_reg <= rd_addr_reg + TILE_AW'(1);
      if (ox_reg == OX_W'(TILE_W - 1)) begin
        ox_reg <= '0;
        oy_reg <= oy_reg + OY_W'(1);
        cx_reg <= x_off_reg;
        cy_reg <= cy_reg + Y_W'(1);
      end else begin
        ox_reg <= ox_reg + OX_W'(1);
        cx_reg <= cx_reg + X_W'(1);
      end
    end
  end

  // read/calc/write alignment pipeline; cleared by reset so no stale write survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < WR_LAT; i++)      addr_pipe[i] <= '0;
      for (int i = 0; i < TILE_RD_LAT; i++) begin
        x_pipe[i] <= '0;
        y_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0]  <= (state_reg == S_ITER);
      addr_pipe[0] <= rd_addr_reg;
      x_pipe[0]    <= cx_reg;
      y_pipe[0]    <= cy_reg;
      for (int i = 1; i < WR_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
      for (int i = 1; i < TILE_RD_LAT; i++) begin
        x_pipe[i] <= x_pipe[i-1];
        y_pipe[i] <= y_pipe[i-1];
      end
    end
  end

  // bus outputs; calculator results only write when the pipeline expects them
  always_comb begin
    bus.busy          = (state_reg != S_IDLE);
    bus.done          = (state_reg == S_DONE);
    bus.tri_rd_addr   = idx_reg[TRI_AW-1:0];
    bus.tile_rd_addr  = rd_addr_reg;
    bus.calc_in_valid = vld_pipe[TILE_RD_LAT-1];
    bus.calc_x        = x_pipe[TILE_RD_LAT-1];
    bus.calc_y        = y_pipe[TILE_RD_LAT-1];
    bus.calc_pixel    = bus.tile_rd_data;
    bus.calc_tri      = tri_reg;
    if (state_reg == S_WIPE) begin
      bus.tile_wr_en   = 1'b1;
      bus.tile_wr_addr = wipe_addr_reg;
      bus.tile_wr_data = wipe_val_reg;
    end else begin
      bus.tile_wr_en   = vld_pipe[WR_LAT-1] & bus.calc_out_valid;
      bus.tile_wr_addr = addr_pipe[WR_LAT-1];
      bus.tile_wr_data = bus.calc_pixel_out;
    end
  end

`ifdef TILE_RASTER_PERF_EN
  logic [31:0] cyc_cnt_reg;
  logic [15:0] tri_cnt_reg;

  // busy-cycle and painted-triangle counters, published when DONE is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_reg <= '0;
      tri_cnt_reg <= '0;
      perf_cycles <= '0;
      perf_tris   <= '0;
    end else begin
      if (accept) begin
        cyc_cnt_reg <= '0;
        tri_cnt_reg <= '0;
      end else if (state_reg != S_IDLE) begin
        cyc_cnt_reg <= cyc_cnt_reg + 32'd1;
        if (state_reg == S_ITER && last_pix) tri_cnt_reg <= tri_cnt_reg + 16'd1;
      end
      if (state_reg == S_DONE) begin
        perf_cycles <= cyc_cnt_reg + 32'd1;
        perf_tris   <= tri_cnt_reg;
      end
    end
  end
`endif

endmodule
